// File: rtl/nvic_pkg.sv
// nvic_pkg: shared constants and helpers for the nvic_ctrl interrupt controller.
//   NUM_IRQ     - number of interrupt lines (IRQ 1..11)
//   IRQ_NUM_W   - width of an IRQ number (0 = none)
//   ST_*        - 2-bit FSM state encodings
//   IRQ_NONE    - IRQ number meaning "no interrupt"
//   irq_onehot  - IRQ number -> pending-bit mask (bit k = IRQ k+1)
package nvic_pkg;

  localparam int NUM_IRQ   = 11;
  localparam int IRQ_NUM_W = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [IRQ_NUM_W-1:0] IRQ_NONE = 4'd0;

  // Map an IRQ number 1..NUM_IRQ onto its pending bit; 0 or out of range gives an empty mask.
  function automatic logic [NUM_IRQ-1:0] irq_onehot(input logic [IRQ_NUM_W-1:0] num);
    logic [NUM_IRQ-1:0] mask;
    mask = {NUM_IRQ{1'b0}};
    for (int k = 1; k <= NUM_IRQ; k++) begin
      if (num == IRQ_NUM_W'(k)) begin
        mask[k-1] = 1'b1;
      end else begin
        mask[k-1] = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/nvic_ctrl_encoder.sv
// NvicEncoder: 1..11 priority encoder, highest-numbered active input wins.
//   i_in[11:1]    - candidate lines, i_in[n] = IRQ n
//   o_encVal[3:0] - number of the highest active input, 0 when none is active
module NvicEncoder
  import nvic_pkg::*;
(
  input  logic [NUM_IRQ:1]     i_in,
  output logic [IRQ_NUM_W-1:0] o_encVal
);

  // Scan upwards so that the last (highest) active line overwrites lower ones.
  always_comb begin
    o_encVal = IRQ_NONE;
    for (int n = 1; n <= NUM_IRQ; n++) begin
      if (i_in[n]) begin
        o_encVal = IRQ_NUM_W'(n);
      end else begin
        o_encVal = o_encVal;
      end
    end
  end

endmodule

// File: rtl/nvic_ctrl.sv
// nvic_ctrl: interrupt controller for 11 IRQ lines with a single, non-nesting ISR slot.
// Raw lines are edge-detected into pending flags, masked by a software enable register,
// and the highest-numbered enabled pending IRQ is offered to the core through a
// request / acknowledge / return handshake.
//   i_clk, i_rst            - clock, synchronous active-high reset
//   i_irq                   - raw level lines, bit k = IRQ k+1
//   i_gie                   - global interrupt enable from the core
//   i_enWr / i_enData       - enable register write
//   i_pendClr / i_pendData  - software pending clear (1 = clear)
//   i_intAck / i_intRet     - core acknowledge / return-from-interrupt
//   o_enVal, o_pendVal      - enable register and pending flags
//   o_intReq, o_intNum      - request to core and the IRQ number offered
//   o_inService, o_activeNum- ISR active flag and IRQ number being serviced
module nvic_ctrl
  import nvic_pkg::*;
#(
  parameter int N_IRQ = NUM_IRQ
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_IRQ-1:0]     i_irq,
  input  logic                 i_gie,
  input  logic                 i_enWr,
  input  logic [N_IRQ-1:0]     i_enData,
  input  logic                 i_pendClr,
  input  logic [N_IRQ-1:0]     i_pendData,
  input  logic                 i_intAck,
  input  logic                 i_intRet,
  output logic [N_IRQ-1:0]     o_enVal,
  output logic [N_IRQ-1:0]     o_pendVal,
  output logic                 o_intReq,
  output logic [IRQ_NUM_W-1:0] o_intNum,
  output logic                 o_inService,
  output logic [IRQ_NUM_W-1:0] o_activeNum
);

  // The encoder is hard-wired for 11 lines; refuse to build any other size.
  if (N_IRQ != 11) begin : g_num_irq_bad
    $error("nvic_ctrl: N_IRQ must be 11");
  end else begin : g_num_irq_ok
  end

  logic [N_IRQ-1:0]     irq_prev_r;
  logic [N_IRQ-1:0]     pend_r;
  logic [N_IRQ-1:0]     en_r;
  logic [1:0]           state_r;
  logic [IRQ_NUM_W-1:0] int_num_r;
  logic [IRQ_NUM_W-1:0] active_num_r;

  logic [N_IRQ-1:0]     rise_s;
  logic [N_IRQ-1:0]     cand_s;
  logic [N_IRQ-1:0]     sw_clr_s;
  logic [N_IRQ-1:0]     ack_clr_s;
  logic [N_IRQ-1:0]     pend_next_s;
  logic                 ack_s;
  logic [IRQ_NUM_W-1:0] enc_s;

  assign rise_s = i_irq & ~irq_prev_r;
  assign cand_s = pend_r & en_r;

  // Acks only count while a request is actually on the wire.
  assign ack_s = (state_r == ST_REQ) && i_intAck;

  NvicEncoder u_encoder (
    .i_in     (cand_s),
    .o_encVal (enc_s)
  );

  // Pending clear sources; a rising edge in the same cycle still wins over both.
  always_comb begin
    sw_clr_s  = {N_IRQ{1'b0}};
    ack_clr_s = {N_IRQ{1'b0}};
    if (i_pendClr) begin
      sw_clr_s = i_pendData;
    end else begin
      sw_clr_s = {N_IRQ{1'b0}};
    end
    // Clear the number the core saw on o_intNum, not the current encoder output.
    if (ack_s) begin
      ack_clr_s = irq_onehot(int_num_r);
    end else begin
      ack_clr_s = {N_IRQ{1'b0}};
    end
    pend_next_s = rise_s | (pend_r & ~(sw_clr_s | ack_clr_s));
  end

  // Edge-detect history, pending flags and enable register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      irq_prev_r <= {N_IRQ{1'b0}};
      pend_r     <= {N_IRQ{1'b0}};
      en_r       <= {N_IRQ{1'b0}};
    end else begin
      irq_prev_r <= i_irq;
      pend_r     <= pend_next_s;
      if (i_enWr) begin
        en_r <= i_enData;
      end else begin
        en_r <= en_r;
      end
    end
  end

  // Request / acknowledge / return handshake; one ISR at a time, no nesting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      int_num_r    <= IRQ_NONE;
      active_num_r <= IRQ_NONE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_gie && (enc_s != IRQ_NONE)) begin
            state_r   <= ST_REQ;
            int_num_r <= enc_s;
          end else begin
            state_r   <= ST_IDLE;
            int_num_r <= IRQ_NONE;
          end
        end
        ST_REQ: begin
          // Ack is checked first so the core is handed the number it vectored on.
          if (i_intAck) begin
            state_r      <= ST_SERVICE;
            active_num_r <= int_num_r;
            int_num_r    <= IRQ_NONE;
          end else if ((enc_s == IRQ_NONE) || !i_gie) begin
            state_r   <= ST_IDLE;
            int_num_r <= IRQ_NONE;
          end else begin
            state_r   <= ST_REQ;
            int_num_r <= enc_s;
          end
        end
        ST_SERVICE: begin
          if (i_intRet) begin
            state_r      <= ST_IDLE;
            active_num_r <= IRQ_NONE;
          end else begin
            state_r      <= ST_SERVICE;
            active_num_r <= active_num_r;
          end
          int_num_r <= IRQ_NONE;
        end
        default: begin
          state_r      <= ST_IDLE;
          int_num_r    <= IRQ_NONE;
          active_num_r <= IRQ_NONE;
        end
      endcase
    end
  end

  assign o_enVal     = en_r;
  assign o_pendVal   = pend_r;
  assign o_intReq    = (state_r == ST_REQ);
  assign o_intNum    = int_num_r;
  assign o_inService = (state_r == ST_SERVICE);
  assign o_activeNum = active_num_r;

endmodule

// File: tb/tb_nvic_ctrl.sv
// tb_nvic_ctrl: directed stimulus for nvic_ctrl with a behavioural reference model
// compared every cycle, plus literal expectations at the key points of each scenario.
module tb_nvic_ctrl;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [10:0] i_irq;
  logic        i_gie;
  logic        i_enWr;
  logic [10:0] i_enData;
  logic        i_pendClr;
  logic [10:0] i_pendData;
  logic        i_intAck;
  logic        i_intRet;
  logic [10:0] o_enVal;
  logic [10:0] o_pendVal;
  logic        o_intReq;
  logic [3:0]  o_intNum;
  logic        o_inService;
  logic [3:0]  o_activeNum;

  int checks = 0;
  int errors = 0;

  nvic_ctrl dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_irq       (i_irq),
    .i_gie       (i_gie),
    .i_enWr      (i_enWr),
    .i_enData    (i_enData),
    .i_pendClr   (i_pendClr),
    .i_pendData  (i_pendData),
    .i_intAck    (i_intAck),
    .i_intRet    (i_intRet),
    .o_enVal     (o_enVal),
    .o_pendVal   (o_pendVal),
    .o_intReq    (o_intReq),
    .o_intNum    (o_intNum),
    .o_inService (o_inService),
    .o_activeNum (o_activeNum)
  );

  always #5 clk = ~clk;

  // Reference model: lines, flags and handshake phase as plain variables.
  bit  m_valid = 1'b0;
  bit  m_prev[11];
  bit  m_pend[11];
  bit  m_en[11];
  bit  m_req;
  bit  m_serv;
  int  m_num;
  int  m_act;

  function automatic logic [10:0] pack(input bit v[11]);
    logic [10:0] r;
    for (int k = 0; k < 11; k++) r[k] = v[k];
    return r;
  endfunction

  always @(posedge clk) begin : model
    int best;
    bit ack;
    bit np[11];
    if (i_rst) begin
      for (int k = 0; k < 11; k++) begin
        m_prev[k] = 1'b0; m_pend[k] = 1'b0; m_en[k] = 1'b0;
      end
      m_req = 1'b0; m_serv = 1'b0; m_num = 0; m_act = 0;
      m_valid = 1'b1;
    end else begin
      best = 0;
      for (int k = 0; k < 11; k++) if (m_pend[k] && m_en[k]) best = k + 1;
      ack = m_req && i_intAck;
      for (int k = 0; k < 11; k++) begin
        bit rise, clr;
        rise = i_irq[k] && !m_prev[k];
        clr  = (i_pendClr && i_pendData[k]) || (ack && (m_num == k + 1));
        np[k] = rise || (m_pend[k] && !clr);
      end
      if (m_serv) begin
        if (i_intRet) begin m_serv = 1'b0; m_act = 0; end
      end else if (m_req) begin
        if (ack) begin
          m_act = m_num; m_num = 0; m_req = 1'b0; m_serv = 1'b1;
        end else if (best == 0 || !i_gie) begin
          m_req = 1'b0; m_num = 0;
        end else begin
          m_num = best;
        end
      end else if (i_gie && best != 0) begin
        m_req = 1'b1; m_num = best;
      end
      for (int k = 0; k < 11; k++) begin
        m_prev[k] = i_irq[k];
        m_pend[k] = np[k];
        if (i_enWr) m_en[k] = i_enData[k];
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (o_enVal !== pack(m_en) || o_pendVal !== pack(m_pend) ||
          o_intReq !== m_req || o_intNum !== 4'(m_num) ||
          o_inService !== m_serv || o_activeNum !== 4'(m_act)) begin
        errors++;
        $display("FAIL model_cmp t=%0t got en=%h pend=%h req=%0d num=%0d srv=%0d act=%0d exp en=%h pend=%h req=%0d num=%0d srv=%0d act=%0d",
                 $time, o_enVal, o_pendVal, o_intReq, o_intNum, o_inService, o_activeNum,
                 pack(m_en), pack(m_pend), m_req, m_num, m_serv, m_act);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic pulse(input logic [10:0] v);
    i_irq = v; tick(); i_irq = 11'h000;
  endtask

  task automatic en_write(input logic [10:0] v);
    i_enWr = 1'b1; i_enData = v; tick(); i_enWr = 1'b0; i_enData = 11'h000;
  endtask

  task automatic do_ack();
    i_intAck = 1'b1; tick(); i_intAck = 1'b0;
  endtask

  task automatic do_ret();
    i_intRet = 1'b1; tick(); i_intRet = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_irq = 11'h000; i_gie = 1'b0; i_enWr = 1'b0; i_enData = 11'h000;
    i_pendClr = 1'b0; i_pendData = 11'h000; i_intAck = 1'b0; i_intRet = 1'b0;
    @(negedge clk);
    tick(2);
    i_rst = 1'b0;
    chk("reset_outputs", {o_enVal, o_pendVal, o_intReq, o_intNum, o_inService, o_activeNum}, 32'd0);

    // Basic request / ack / return for IRQ3.
    en_write(11'h7FF);
    i_gie = 1'b1;
    pulse(11'h004);
    chk("basic_pend", o_pendVal, 11'h004);
    chk("basic_noreq_yet", o_intReq, 1'b0);
    tick();
    chk("basic_req", {o_intReq, o_intNum}, {1'b1, 4'd3});
    do_ack();
    chk("basic_ack_pend", o_pendVal, 11'h000);
    chk("basic_ack_srv", {o_inService, o_activeNum, o_intReq}, {1'b1, 4'd3, 1'b0});
    do_ret();
    chk("basic_ret", {o_inService, o_activeNum, o_intReq, o_intNum}, 10'd0);

    // Priority and retarget.
    pulse(11'h011);
    chk("prio_pend", o_pendVal, 11'h011);
    tick();
    chk("prio_num5", o_intNum, 4'd5);
    pulse(11'h400);
    chk("retarget_not_yet", o_intNum, 4'd5);
    tick();
    chk("retarget_num11", o_intNum, 4'd11);
    do_ack();
    chk("retarget_ack", {o_activeNum, o_pendVal}, {4'd11, 11'h011});
    do_ret();
    tick();
    chk("after_ret_num5", {o_intReq, o_intNum}, {1'b1, 4'd5});
    do_ack();
    do_ret();
    tick();
    chk("after_ret_num1", {o_intReq, o_intNum}, {1'b1, 4'd1});
    do_ack();
    do_ret();
    chk("prio_drained", o_pendVal, 11'h000);

    // Masking and withdraw.
    en_write(11'h001);
    pulse(11'h008);
    tick();
    chk("mask_noreq", {o_intReq, o_pendVal}, {1'b0, 11'h008});
    en_write(11'h008);
    tick();
    chk("unmask_req4", {o_intReq, o_intNum}, {1'b1, 4'd4});
    en_write(11'h000);
    tick();
    chk("withdraw", {o_intReq, o_intNum, o_pendVal}, {1'b0, 4'd0, 11'h008});
    i_pendClr = 1'b1; i_pendData = 11'h008; tick(); i_pendClr = 1'b0; i_pendData = 11'h000;
    chk("sw_clear", o_pendVal, 11'h000);
    en_write(11'h7FF);

    // Set/clear collisions.
    i_irq = 11'h040; i_pendClr = 1'b1; i_pendData = 11'h040;
    tick();
    i_irq = 11'h000; i_pendClr = 1'b0; i_pendData = 11'h000;
    chk("set_beats_swclr", o_pendVal, 11'h040);
    tick();
    chk("req7", {o_intReq, o_intNum}, {1'b1, 4'd7});
    i_irq = 11'h040; i_intAck = 1'b1;
    tick();
    i_irq = 11'h000; i_intAck = 1'b0;
    chk("set_beats_ackclr", {o_pendVal, o_activeNum, o_inService}, {11'h040, 4'd7, 1'b1});
    do_ret();
    tick();
    chk("rerequest7", {o_intReq, o_intNum}, {1'b1, 4'd7});
    do_ack();
    do_ret();

    // Level held high sets pending once; service blocks new requests.
    i_gie = 1'b0;
    i_irq = 11'h002;
    tick(20);
    chk("level_single", o_pendVal, 11'h002);
    i_pendClr = 1'b1; i_pendData = 11'h002; tick(); i_pendClr = 1'b0; i_pendData = 11'h000;
    chk("level_no_reset", o_pendVal, 11'h000);
    i_irq = 11'h000;
    i_gie = 1'b1;
    do_ack();
    chk("spurious_ack", {o_inService, o_activeNum, o_intReq}, 6'd0);
    pulse(11'h004);
    tick();
    do_ack();
    pulse(11'h100);
    tick(3);
    chk("srv_blocks", {o_intReq, o_inService, o_pendVal}, {1'b0, 1'b1, 11'h100});
    do_ret();
    chk("ret_cycle_noreq", o_intReq, 1'b0);
    tick();
    chk("req9_after_ret", {o_intReq, o_intNum}, {1'b1, 4'd9});
    do_ack();
    do_ret();

    // Reset mid-operation, and a line held high through reset.
    i_gie = 1'b0;
    pulse(11'h3FF);
    i_gie = 1'b1;
    tick();
    chk("req10", o_intNum, 4'd10);
    do_ack();
    pulse(11'h3FF);
    chk("srv_full_pend", {o_pendVal, o_inService}, {11'h3FF, 1'b1});
    i_rst = 1'b1; i_irq = 11'h001;
    tick();
    i_rst = 1'b0;
    chk("midop_reset", {o_enVal, o_pendVal, o_intReq, o_intNum, o_inService, o_activeNum}, 32'd0);
    tick();
    chk("held_through_reset", o_pendVal, 11'h001);
    i_irq = 11'h000;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
